// File: rtl/demo_sched_pkg.sv
// Shared types and helpers for the out-of-order scheduler front end.
// Tag-window test works on plain integers so it serves any DEPTH.
package demo_sched_pkg;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_OK,
        RSP_ERR
    } rsp_kind_e;

    // head==tail is ambiguous on its own; count resolves empty vs. full.
    function automatic logic tag_in_window(input int unsigned tag,
                                           input int unsigned head,
                                           input int unsigned tail,
                                           input int unsigned count,
                                           input int unsigned depth);
        if (count == 0)
            return 1'b0;
        if (count >= depth)
            return 1'b1;
        if (head < tail)
            return (tag >= head) && (tag < tail);
        return (tag >= head) || (tag < tail);
    endfunction

endpackage

// File: rtl/demo_rr_arb.sv
// Combinational round-robin arbiter: first request at or after rr_ptr_i, wrapping.
module demo_rr_arb #(
    parameter int  NUM_REQ = 4,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SRC_W-1:0]   rr_ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SRC_W-1:0]   idx_o
);

    int unsigned      pos;
    logic [SRC_W-1:0] pos_idx;
    logic             found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(rr_ptr_i) + i;
            if (pos >= NUM_REQ)
                pos = pos - NUM_REQ;
            pos_idx = SRC_W'(pos);
            if (en_i && !found && req_i[pos_idx]) begin
                found          = 1'b1;
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/demo_ooo_sched.sv
// Round-robin issue front end with a reorder buffer: tags issue in order,
// responses land out of order, results retire in issue order.
module demo_ooo_sched
    import demo_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DEPTH   = 8,
    parameter int  DATA_W  = 4,
    localparam int TAG_W   = $clog2(DEPTH),
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_vld,
    output logic [NUM_REQ-1:0] req_gnt,
    output logic               eng_req_vld,
    output logic [TAG_W-1:0]   eng_req_tag,
    input  logic               eng_rsp_vld,
    input  logic [TAG_W-1:0]   eng_rsp_tag,
    input  logic [DATA_W-1:0]  eng_rsp_data,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [SRC_W-1:0]   out_src,
    output logic [TAG_W-1:0]   out_tag,
    output logic [DATA_W-1:0]  out_data,
    output logic [TAG_W:0]     outstanding,
    output logic               err_o
);

    typedef struct packed {
        logic              done;
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    rob_entry_t       rob_q [DEPTH];
    rob_entry_t       rob_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
    logic [TAG_W:0]   cnt_q, cnt_d;
    logic [SRC_W-1:0] rr_q, rr_d;
    logic [SRC_W-1:0] gnt_idx;
    logic             iss_vld_q, iss_vld_d;
    logic             err_q, err_d;
    logic             full, accept, retire;
    rsp_kind_e        rsp_kind;

    // Full uses the registered count, so a retire this cycle cannot free a grant.
    assign full = (cnt_q == (TAG_W+1)'(DEPTH));

    demo_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i    (req_vld),
        .rr_ptr_i (rr_q),
        .en_i     (!full),
        .gnt_o    (req_gnt),
        .idx_o    (gnt_idx)
    );

    assign accept  = |(req_vld & req_gnt);
    assign out_vld = (cnt_q != '0) && rob_q[head_q].done;
    assign retire  = out_vld && out_rdy;

    assign out_src     = rob_q[head_q].src;
    assign out_tag     = head_q;
    assign out_data    = rob_q[head_q].data;
    assign outstanding = cnt_q;
    assign err_o       = err_q;
    assign eng_req_vld = iss_vld_q;
    assign eng_req_tag = iss_tag_q;

    // Window is judged on registered head/tail, so a slot allocated this cycle is not yet legal.
    always_comb begin
        rsp_kind = RSP_NONE;
        if (eng_rsp_vld) begin
            if (tag_in_window(32'(eng_rsp_tag), 32'(head_q), 32'(tail_q), 32'(cnt_q), DEPTH)
                && !rob_q[eng_rsp_tag].done)
                rsp_kind = RSP_OK;
            else
                rsp_kind = RSP_ERR;
        end
    end

    always_comb begin
        rob_d     = rob_q;
        head_d    = head_q;
        tail_d    = tail_q;
        rr_d      = rr_q;
        err_d     = err_q;
        iss_vld_d = accept;
        iss_tag_d = iss_tag_q;

        if (accept) begin
            rob_d[tail_q].done = 1'b0;
            rob_d[tail_q].src  = gnt_idx;
            iss_tag_d          = tail_q;
            tail_d             = tail_q + TAG_W'(1);
            rr_d               = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
        end

        if (rsp_kind == RSP_OK) begin
            rob_d[eng_rsp_tag].done = 1'b1;
            rob_d[eng_rsp_tag].data = eng_rsp_data;
        end else if (rsp_kind == RSP_ERR) begin
            err_d = 1'b1;
        end

        if (retire) begin
            rob_d[head_q].done = 1'b0;
            head_d             = head_q + TAG_W'(1);
        end

        cnt_d = cnt_q + (TAG_W+1)'(accept) - (TAG_W+1)'(retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rob_q     <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            rr_q      <= '0;
            iss_vld_q <= 1'b0;
            iss_tag_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rob_q     <= rob_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            iss_vld_q <= iss_vld_d;
            iss_tag_q <= iss_tag_d;
            err_q     <= err_d;
        end
    end

endmodule
